instruction_prefetch: RTL
=========================

Name: instruction_prefetch

Overview:
- Fetch stage between the program counter domain and the decode/execute core.
- Owns the PC and drives the combinational instruction ROM address every cycle.
- Captures returned 28-bit instruction words into a small prefetch queue and presents them to decode with a valid/ready handshake.
- Handles taken branches and jumps by flushing the queue and redirecting the PC.

Parameters:
- INST_WIDTH, 28, instruction word width (opcode + 24-bit operand field)
- ADDR_WIDTH, 16, ROM address / PC width
- DEPTH, 4, prefetch queue entries (power of two, ≥2)
- RESET_PC, 16'd0, PC value loaded at reset

Ports:
- Clock  input  1  system clock
- Reset  input  1  asynchronous, active-low reset
- oAddress  output  ADDR_WIDTH  ROM address (current fetch PC)
- iInstruction  input  INST_WIDTH  ROM data for oAddress, same cycle (combinational ROM)
- oInstValid  output  1  queue head holds a valid instruction
- oInstruction  output  INST_WIDTH  queue head instruction
- oInstPC  output  ADDR_WIDTH  address the head instruction was fetched from
- iInstReady  input  1  decode consumes head this cycle when oInstValid=1
- iRedirect  input  1  taken branch/jump: flush and refetch
- iRedirectPC  input  ADDR_WIDTH  new fetch address, sampled when iRedirect=1
- oQueueCount  output  log2(DEPTH)+1  occupied entries (debug/verification)

Behaviour:
- Interface timing: one clock; reset is asynchronous and active-low.
- Reset (Reset=0):
  - PC=RESET_PC, queue empty, count=0.
  - oInstValid=0, oInstruction=0, oInstPC=0.
  - oAddress=RESET_PC.
- Signal definitions:
  - pop = oInstValid & iInstReady.
  - push = !iRedirect & (count<DEPTH | pop).
  - Pass-through when full is allowed: a full queue with a pop also pushes.
- Fetch on push:
  - At the clock edge, store {iInstruction, PC} at the tail.
  - PC <= PC+1, wrapping 16'hFFFF -> 16'h0000 with no flag.
- oAddress always equals PC (registered), so the ROM sees a stable address for the whole cycle.
- Latency:
  - Instruction at address A is fetched in cycle N.
  - It appears at the head in cycle N+1 at the earliest, with oInstValid=1.
  - After reset release, first valid is in cycle 1.
- Head outputs (oInstruction, oInstPC) are driven from queue registers; no combinational path from iInstruction to the outputs.
- When empty, oInstValid=0 and oInstruction/oInstPC hold their last values; verification must not check them while invalid.
- Redirect (iRedirect=1), with priority over everything:
  - At the edge: queue cleared (count=0, pointers reset), PC <= iRedirectPC.
  - No push and no pop take effect that cycle, even if iInstReady=1.
  - Cycle R+1: oInstValid=0, oAddress=iRedirectPC.
  - Cycle R+2: target instruction valid at the head.
- Back-to-back redirects: only the last applies; each one flushes again.
- Full and no pop: no push; PC holds; oAddress stable.
- Count update: count += push − (pop & !iRedirect). Count is never >DEPTH and never <0.
- Reset asserted mid-operation: immediate async clear to reset state; any in-flight handshake is dropped.

Decomposition:
- Shared include, alongside the existing opcode definitions:
  - INST_WIDTH, ADDR_WIDTH, RESET_PC.
  - Field slices: opcode [27:24], operand [23:0].
- One sub-module, prefetch_fifo: synchronous FIFO, width INST_WIDTH+ADDR_WIDTH, depth DEPTH.
  - Ports: push/pop/flush, full/empty/count.
  - Flush has priority over push and pop.
- instruction_prefetch keeps the PC register, push/redirect logic, and output mapping.

Test Plan:
- Reset then iInstReady=1 constantly, ROM word = {4'h0, 8'h0, address} -> oInstValid from cycle 1; oInstPC sequence 0,1,2,3,... one per cycle; oInstruction[15:0]==oInstPC.
- iInstReady=0 for 10 cycles -> oQueueCount rises 1..4 and saturates; oAddress freezes at 4; raising iInstReady yields PCs 0,1,2,3,4,5 with no gap or duplicate.
- With the queue full (count=4), iInstReady=1 for a single cycle -> head advances from PC 0 to 1, PC 4 enters the queue in the same cycle, count stays 4.
- Redirect at iRedirectPC=16'h0002 while count=3 and iInstReady=1 -> next cycle oInstValid=0 and count=0; the cycle after, oInstPC=2; the popped entry is not counted as consumed.
- PC wrap: iRedirectPC=16'hFFFE -> heads 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001.
- Assert Reset low mid-stream with count=2 -> outputs immediately oInstValid=0, oAddress=0, count=0; the first valid after release is PC 0.

Source files
------------

// File: rtl/instruction_prefetch_pkg.sv
// Shared fetch-stage definitions: instruction geometry, reset PC, opcode field helpers.
package instruction_prefetch_pkg;

    localparam int INST_WIDTH = 28;
    localparam int ADDR_WIDTH = 16;
    localparam logic [ADDR_WIDTH-1:0] RESET_PC = 16'd0;

    localparam int OPCODE_MSB  = 27;
    localparam int OPCODE_LSB  = 24;
    localparam int OPERAND_MSB = 23;
    localparam int OPERAND_LSB = 0;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_LOAD = 4'h1,
        OP_STORE= 4'h2,
        OP_ADD  = 4'h3,
        OP_SUB  = 4'h4,
        OP_JMP  = 4'h8,
        OP_BEQ  = 4'h9,
        OP_BNE  = 4'hA
    } opcode_e;

    function automatic logic [OPCODE_MSB-OPCODE_LSB:0] inst_opcode(input logic [INST_WIDTH-1:0] inst);
        return inst[OPCODE_MSB:OPCODE_LSB];
    endfunction

    function automatic logic [OPERAND_MSB-OPERAND_LSB:0] inst_operand(input logic [INST_WIDTH-1:0] inst);
        return inst[OPERAND_MSB:OPERAND_LSB];
    endfunction

endpackage

// File: rtl/instruction_prefetch_fifo.sv
// Synchronous prefetch queue; flush wins over push/pop, push into a full queue only alongside a pop.
module instruction_prefetch_fifo #(
    parameter int WIDTH = 44,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               wr_ptr, rd_ptr;
    logic                        do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & !empty;
    assign do_push = push & (!full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // When full, wr_ptr == rd_ptr: the slot being read out is rewritten at this edge.
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/instruction_prefetch.sv
// Fetch stage: owns the PC, drives the ROM address, queues fetched words and hands them to decode.
module instruction_prefetch #(
    parameter int                    INST_WIDTH = instruction_prefetch_pkg::INST_WIDTH,
    parameter int                    ADDR_WIDTH = instruction_prefetch_pkg::ADDR_WIDTH,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = instruction_prefetch_pkg::RESET_PC,
    localparam int                   CW         = $clog2(DEPTH) + 1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    output logic [ADDR_WIDTH-1:0] oAddress,
    input  logic [INST_WIDTH-1:0] iInstruction,
    output logic                  oInstValid,
    output logic [INST_WIDTH-1:0] oInstruction,
    output logic [ADDR_WIDTH-1:0] oInstPC,
    input  logic                  iInstReady,
    input  logic                  iRedirect,
    input  logic [ADDR_WIDTH-1:0] iRedirectPC,
    output logic [CW-1:0]         oQueueCount
);

    localparam int EW = INST_WIDTH + ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] pc;
    logic                  pop, push, full, empty;
    logic [EW-1:0]         head, hold_q;

    assign oInstValid = !empty;
    assign pop        = oInstValid & iInstReady;
    assign push       = !iRedirect & (!full | pop);

    instruction_prefetch_fifo #(
        .WIDTH(EW),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (Clock),
        .rst_n(Reset),
        .push (push),
        .pop  (pop & !iRedirect),
        .flush(iRedirect),
        .wdata({iInstruction, pc}),
        .rdata(head),
        .full (full),
        .empty(empty),
        .count(oQueueCount)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)
            pc <= RESET_PC;
        else if (iRedirect)
            pc <= iRedirectPC;
        else if (push)
            pc <= pc + ADDR_WIDTH'(1);
    end

    // Head outputs keep the last presented entry while the queue is empty.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)
            hold_q <= '0;
        else if (!empty)
            hold_q <= head;
    end

    assign oAddress                = pc;
    assign {oInstruction, oInstPC} = empty ? hold_q : head;

endmodule
